// File: rtl/spi_accel_reader_if.sv
// spi_accel_reader_if: Pmod SPI pins plus the x_val producer signals of the accelerometer reader
interface spi_accel_reader_if;
    logic        spi_miso;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic [10:0] x_val;
    logic        x_valid;
    logic        busy;

    modport master (
        input  spi_miso,
        output spi_sclk, spi_mosi, spi_cs_n, x_val, x_valid, busy
    );

    modport slave (
        output spi_miso,
        input  spi_sclk, spi_mosi, spi_cs_n, x_val, x_valid, busy
    );
endinterface

// File: rtl/spi_accel_reader.sv
// spi_accel_reader: puts the ADXL362 into measurement mode, then polls XDATA over SPI mode 0
module spi_accel_reader #(
    parameter int CLK_DIV        = 50,
    parameter int STARTUP_CYCLES = 500_000,
    parameter int POLL_CYCLES    = 100_000
) (
    input  logic               clk,
    input  logic               rst,
    spi_accel_reader_if.master bus
);
    localparam logic [2:0] S_STARTUP  = 3'd0;
    localparam logic [2:0] S_CS_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_CS_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;

    localparam logic [31:0] INIT_CMD = 32'h0A2D_0200;
    localparam logic [31:0] READ_CMD = 32'h0B0E_0000;

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [31:0] poll;
    logic [4:0]  bit_cnt;
    logic [31:0] tx;
    logic [15:0] rx;
    logic        is_read;
    logic        sclk;
    logic        cs_n;
    logic        cap;
    logic [10:0] x_val;
    logic        x_valid;
    logic        div_done;
    logic        last_bit;
    logic        start;
    logic        unused_rx;

    assign div_done  = cnt == CLK_DIV - 1;
    assign last_bit  = bit_cnt == (is_read ? 5'd31 : 5'd23);
    assign start     = (state == S_STARTUP && cnt == STARTUP_CYCLES - 1) ||
                       (state == S_GAP && cnt >= CLK_DIV - 1 && poll == POLL_CYCLES - 1);
    assign unused_rx = ^{rx[8], rx[7:4]};

    assign bus.spi_sclk = sclk;
    assign bus.spi_mosi = tx[31];
    assign bus.spi_cs_n = cs_n;
    assign bus.x_val    = x_val;
    assign bus.x_valid  = x_valid;
    assign bus.busy     = !cs_n;

    // Sequencer: startup wait, CS framing, SCLK half-periods, shifting and the poll timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_STARTUP;
            cnt     <= '0;
            poll    <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            is_read <= 1'b0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            cap     <= 1'b0;
        end else begin
            poll <= start ? '0 : poll + 1'b1;
            cap  <= state == S_CS_HOLD && div_done && is_read;
            if (start) begin
                state   <= S_CS_SETUP;
                cnt     <= '0;
                bit_cnt <= '0;
                cs_n    <= 1'b0;
                is_read <= state == S_GAP;
                tx      <= state == S_GAP ? READ_CMD : INIT_CMD;
            end else if (state == S_STARTUP || state == S_GAP) begin
                cnt <= cnt + 1'b1;
            end else if (state == S_CS_HOLD) begin
                cnt <= div_done ? '0 : cnt + 1'b1;
                if (div_done) begin
                    cs_n  <= 1'b1;
                    state <= S_GAP;
                end
            end else begin
                cnt <= div_done ? '0 : cnt + 1'b1;
                if (div_done) begin
                    sclk  <= !sclk;
                    state <= sclk && last_bit ? S_CS_HOLD : S_SHIFT;
                    if (!sclk && is_read)
                        rx <= {rx[14:0], bus.spi_miso};
                    if (sclk && !last_bit) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx      <= {tx[30:0], 1'b0};
                    end
                end
            end
        end
    end

    // Publish {XDATA_H[3:0], XDATA_L} >> 1 one clk after CS rises at the end of a read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_val   <= '0;
            x_valid <= 1'b0;
        end else begin
            x_valid <= cap;
            if (cap)
                x_val <= {rx[3:0], rx[15:9]};
        end
    end
endmodule

// File: tb/tb_spi_accel_reader.sv
// tb_spi_accel_reader: directed sequence with an ADXL362 slave model, protocol monitor and x_val scoreboard
module tb_spi_accel_reader;
    localparam int CLK_DIV = 2;
    localparam int STARTUP = 10;
    localparam int POLL    = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_xv = 0;

    spi_accel_reader_if bus();

    spi_accel_reader #(
        .CLK_DIV(CLK_DIV),
        .STARTUP_CYCLES(STARTUP),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [10:0] sb[$];
    int          txn_bits[$];
    logic [31:0] txn_data[$];
    logic [7:0]  resp_l = 8'h00;
    logic [7:0]  resp_h = 8'h00;
    logic [31:0] sh = '0;
    logic [31:0] mdata = '0;
    int          rises = 0;
    int          last_rise = 0;
    int          last_fall = 0;
    int          last_cs_rise = 0;
    int          last_xv = 0;
    bit          have_fall = 0;
    bit          have_cs_rise = 0;
    bit          have_xv = 0;
    logic        p_sclk = 1'b0;
    logic        p_mosi = 1'b0;
    logic        p_cs = 1'b1;
    logic        p_xv = 1'b0;
    logic        p_rst = 1'b0;

    // Slave model, protocol checker and scoreboard consumer, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst || !p_rst) begin
            rises = 0;
            mdata = '0;
            have_fall = 0;
            have_cs_rise = 0;
            have_xv = 0;
            bus.spi_miso = 1'bx;
        end else begin
            if (bus.spi_cs_n !== p_cs) begin
                check("cs_edge_sclk_low", {p_sclk, bus.spi_sclk}, 0);
                check("busy_vs_cs", bus.busy, !bus.spi_cs_n);
                if (!bus.spi_cs_n) begin
                    if (have_fall) check("poll_spacing", cyc - last_fall, POLL);
                    if (have_cs_rise) check("cs_high_len", (cyc - last_cs_rise) >= CLK_DIV, 1);
                    have_fall = 1;
                    last_fall = cyc;
                    rises = 0;
                    mdata = '0;
                    sh = {16'h0000, resp_l, resp_h};
                    bus.spi_miso = sh[31];
                end else begin
                    txn_bits.push_back(rises);
                    txn_data.push_back(mdata);
                    have_cs_rise = 1;
                    last_cs_rise = cyc;
                    bus.spi_miso = 1'bx;
                end
            end
            if (bus.spi_sclk !== p_sclk) begin
                check("sclk_edge_cs_low", {p_cs, bus.spi_cs_n}, 0);
                if (bus.spi_sclk) begin
                    check("mosi_stable", bus.spi_mosi, p_mosi);
                    if (rises > 0) check("sclk_period", cyc - last_rise, 2 * CLK_DIV);
                    last_rise = cyc;
                    rises++;
                    mdata = {mdata[30:0], bus.spi_mosi};
                end else begin
                    sh = sh << 1;
                    bus.spi_miso = sh[31];
                end
            end
            if (p_xv) check("xv_width", bus.x_valid, 0);
            if (bus.x_valid) begin
                n_xv++;
                check("xv_latency", cyc - last_cs_rise, 1);
                if (have_xv) check("xv_spacing", cyc - last_xv, POLL);
                have_xv = 1;
                last_xv = cyc;
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) check("x_val", bus.x_val, sb.pop_front());
            end
        end
        p_sclk = bus.spi_sclk;
        p_mosi = bus.spi_mosi;
        p_cs   = bus.spi_cs_n;
        p_xv   = bus.x_valid;
        p_rst  = rst;
    end

    task automatic wait_startup(input string tag);
        int n = 0;
        rst = 1'b1;
        while (bus.spi_cs_n !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, STARTUP);
    endtask

    task automatic wait_txn(input string tag, input int bits, input logic [31:0] data);
        int n = 0;
        while (txn_bits.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, txn_bits.size() > 0, 1);
        if (txn_bits.size() > 0) begin
            check({tag, "_rises"}, txn_bits.pop_front(), bits);
            check({tag, "_mosi"}, txn_data.pop_front(), data);
        end
    endtask

    task automatic do_read(input string tag, input logic [7:0] l, input logic [7:0] h, input logic [10:0] exp);
        resp_l = l;
        resp_h = h;
        sb.push_back(exp);
        wait_txn(tag, 32, 32'h0B0E_0000);
        repeat (3) @(negedge clk);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int n;
        int xv_before;
        repeat (3) @(negedge clk);
        check("rst_sclk", bus.spi_sclk, 0);
        check("rst_mosi", bus.spi_mosi, 0);
        check("rst_cs_n", bus.spi_cs_n, 1);
        check("rst_x_val", bus.x_val, 0);
        check("rst_x_valid", bus.x_valid, 0);
        check("rst_busy", bus.busy, 0);

        wait_startup("startup_delay");
        check("busy_in_txn", bus.busy, 1);
        wait_txn("init", 24, 32'h000A_2D02);
        repeat (3) @(negedge clk);
        check("init_no_xv", n_xv, 0);
        check("init_x_val", bus.x_val, 0);

        do_read("read_pos", 8'hFE, 8'h07, 11'h3FF);
        do_read("read_min", 8'h00, 8'hF8, 11'h400);
        do_read("read_m1", 8'hFE, 8'hFF, 11'h7FF);
        do_read("read_mix", 8'h34, 8'hA2, 11'h11A);

        resp_l = 8'h55;
        resp_h = 8'hAA;
        xv_before = n_xv;
        n = 0;
        while (rises != 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached", rises, 20);
        #2 rst = 1'b0;
        #1;
        check("abort_cs_n", bus.spi_cs_n, 1);
        check("abort_sclk", bus.spi_sclk, 0);
        check("abort_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("abort_x_val", bus.x_val, 0);
        check("abort_x_valid", bus.x_valid, 0);
        check("abort_no_xv", n_xv, xv_before);

        wait_startup("restart_delay");
        wait_txn("reinit", 24, 32'h000A_2D02);
        do_read("read_after", 8'h10, 8'h03, 11'h188);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL timeout: observed no finish, required finish before 50000 clks");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_accel_reader.md
Name: spi_accel_reader

Overview:
- SPI master that configures the on-board ADXL362 accelerometer and then polls its X-axis data at a fixed rate.
- Produces the 11-bit x_val consumed by the 7-segment controller and the servo path. It is the producer side of the x_val interface.
- Sits between the Pmod SPI pins and the display/servo logic, in the 100 MHz clk domain.

Parameters:
- CLK_DIV, 50: clk cycles per SCLK half-period (100 MHz gives 1 MHz SCLK); must be ≥2.
- STARTUP_CYCLES, 500_000: clk cycles from reset release to start of the init write (5 ms).
- POLL_CYCLES, 100_000: clk cycles between consecutive transaction starts (1 kHz); must be > 70*CLK_DIV.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset; asynchronous, active-low.
- spi_miso  input  1  serial data from accelerometer.
- spi_sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_mosi  output  1  serial data to accelerometer, MSB first.
- spi_cs_n  output  1  chip select, active-low.
- x_val  output  11  latest X sample, two's complement.
- x_valid  output  1  one-clk pulse when x_val updates.
- busy  output  1  high while spi_cs_n is low.

Behaviour:
- Reset (rst=0, asynchronous): spi_sclk=0, spi_mosi=0, spi_cs_n=1, x_val=0, x_valid=0, busy=0, FSM to S_STARTUP, all counters 0.
- Reset mid-transaction aborts immediately: cs_n rises asynchronously, no partial x_val update, sequence restarts with the init write.
- FSM states:
  - S_STARTUP: count STARTUP_CYCLES → S_CS_SETUP with the init transaction loaded.
  - S_CS_SETUP: cs_n=0, MOSI=first bit, hold CLK_DIV cycles → S_SHIFT.
  - S_SHIFT: clock out the 8*N bits.
  - S_CS_HOLD: after the last falling edge, hold CLK_DIV cycles → cs_n=1.
  - S_GAP: cs_n high for ≥CLK_DIV cycles, then wait until the poll timer expires → S_CS_SETUP with the read transaction loaded.
- Init transaction, once per reset: 3 bytes, 0x0A, 0x2D, 0x02 (write POWER_CTL = measurement mode). MISO is ignored.
- Read transaction, repeated: 4 bytes, 0x0B, 0x0E, dummy, dummy. Capture byte 3 = XDATA_L and byte 4 = XDATA_H. MOSI=0 during the dummy bytes.
- Bit timing:
  - SCLK low for CLK_DIV clks, then high for CLK_DIV clks.
  - MISO is sampled in the clk cycle where SCLK goes 0→1.
  - MOSI changes only in the clk cycle where SCLK goes 1→0, or at cs_n fall for the first bit.
  - Exactly 8*N rising edges per transaction; SCLK idles 0.
- Poll timer: restarts at each transaction's cs_n fall. The next transaction's cs_n falls exactly POLL_CYCLES clks after the previous one, so x_valid pulses are exactly POLL_CYCLES apart. The first read cs_n fall occurs POLL_CYCLES after the init cs_n fall.
- Arithmetic: raw[11:0] = {XDATA_H[3:0], XDATA_L}, signed. XDATA_H[7:4] is ignored. x_val = raw[11:1] (drop LSB, sign preserved), so the range is −1024..1023.
- Output latency: x_val is registered and x_valid pulses high for 1 clk, both in the cycle after cs_n rises at the end of a read. The init transaction never pulses x_valid.
- busy equals ~spi_cs_n, registered.
- MISO is not sampled while cs_n=1, so an X on spi_miso has no effect.

Test Plan:
- Reset, then release (STARTUP_CYCLES=10, CLK_DIV=2) → cs_n falls 10 clks after release; MOSI bytes 0x0A, 0x2D, 0x02; exactly 24 SCLK rises, period 4 clks; no x_valid; x_val=0.
- Read with slave model returning L=0xFE, H=0x07 → MOSI 0x0B, 0x0E, then 0x00 on dummy bytes; 32 SCLK rises; one clk after cs_n rise x_val=0x3FF and x_valid=1 for exactly 1 clk.
- Negative value, L=0x00, H=0xF8 → x_val=0x400 (−1024). Then L=0xFE, H=0xFF → x_val=0x7FF (−1).
- Poll spacing (POLL_CYCLES=400) → successive cs_n falls exactly 400 clks apart and x_valid pulses 400 clks apart; cs_n high ≥CLK_DIV between transactions.
- Assert rst during bit 20 of a read → cs_n=1 and sclk=0 in the same cycle, x_val=0, no x_valid. After release, the next transaction is the init write again.
- Protocol checker over all tests → MOSI stable across every SCLK rising edge, SCLK=0 whenever cs_n toggles, no SCLK edges while cs_n=1.
